// File: rtl/capture_pkg.sv
// Shared defaults and types for the nibble capture path.
package capture_pkg;
  localparam int unsigned DEF_DATA_WIDTH = 4;
  localparam int unsigned DEF_PACK       = 2;
  localparam int unsigned DEF_DEPTH      = 4;
  localparam int unsigned DEF_CNT_WIDTH  = 8;
  localparam int unsigned DEF_W          = DEF_DATA_WIDTH * DEF_PACK;
  localparam int unsigned DEF_LVL_W      = $clog2(DEF_DEPTH) + 1;

  typedef logic [DEF_W-1:0] word_t;
endpackage

// File: rtl/capture_fifo.sv
// Show-ahead FIFO with a registered head word; a push into a full FIFO is
// accepted only when a pop happens in the same cycle.
module capture_fifo #(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned DEPTH = 4
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       push,
  input  logic [WIDTH-1:0]           wdata,
  input  logic                       pop,
  output logic [WIDTH-1:0]           rdata,
  output logic                       valid,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       full_c
);
  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr, rd_ptr, rd_nxt;
  logic [LVL_W-1:0] level_nxt;
  logic [WIDTH-1:0] head_nxt;
  logic             push_acc, pop_acc;

  assign full_c = (level == LVL_W'(DEPTH));

  always_comb begin
    pop_acc   = pop && valid;
    push_acc  = push && (!full_c || pop_acc);
    rd_nxt    = pop_acc ? rd_ptr + PTR_W'(1) : rd_ptr;
    level_nxt = level;
    if (push_acc && !pop_acc)      level_nxt = level + LVL_W'(1);
    else if (!push_acc && pop_acc) level_nxt = level - LVL_W'(1);
    // The incoming word becomes head when it lands in the slot the read pointer moves to.
    head_nxt  = (push_acc && (rd_nxt == wr_ptr)) ? wdata : mem[rd_nxt];
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < int'(DEPTH); i++) mem[i] <= '0;
      wr_ptr <= '0;
      rd_ptr <= '0;
      level  <= '0;
      valid  <= 1'b0;
      rdata  <= '0;
    end else begin
      if (push_acc) begin
        mem[wr_ptr] <= wdata;
        wr_ptr      <= wr_ptr + PTR_W'(1);
      end
      rd_ptr <= rd_nxt;
      level  <= level_nxt;
      valid  <= (level_nxt != '0);
      rdata  <= head_nxt;
    end
  end
endmodule

// File: rtl/nibble_capture_packer.sv
// Packs consecutive pipeline samples into words, buffers them in a FIFO and
// accounts for words lost to back-pressure.
module nibble_capture_packer
  import capture_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = DEF_DATA_WIDTH,
  parameter int unsigned PACK       = DEF_PACK,
  parameter int unsigned DEPTH      = DEF_DEPTH,
  parameter int unsigned CNT_WIDTH  = DEF_CNT_WIDTH
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic [DATA_WIDTH-1:0]      in,
  input  logic                       flush,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [DATA_WIDTH*PACK-1:0] out_data,
  output logic [$clog2(DEPTH):0]     level,
  output logic                       overflow,
  input  logic                       clear_overflow,
  output logic [CNT_WIDTH-1:0]       drop_cnt
);
  localparam int unsigned W      = DATA_WIDTH * PACK;
  localparam int unsigned LANE_W = (PACK > 1) ? $clog2(PACK) : 1;

  logic [LANE_W-1:0] lane;
  logic [W-1:0]      partial, word_c;
  logic              done_c, pop_c, drop_c, full_c;

  // Merge the current sample into the partial word at its lane.
  always_comb begin
    word_c = partial;
    if (in_valid) word_c[lane*DATA_WIDTH +: DATA_WIDTH] = in;
    done_c = (in_valid && (lane == LANE_W'(PACK - 1))) ||
             (flush && ((lane != '0) || in_valid));
    pop_c  = out_valid && out_ready;
    drop_c = done_c && full_c && !pop_c;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane    <= '0;
      partial <= '0;
    end else if (done_c) begin
      lane    <= '0;
      partial <= '0;
    end else if (in_valid) begin
      lane    <= lane + LANE_W'(1);
      partial <= word_c;
    end
  end

  // Overflow set takes priority over a same-cycle clear; counter saturates.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      overflow <= 1'b0;
      drop_cnt <= '0;
    end else begin
      if (drop_c)              overflow <= 1'b1;
      else if (clear_overflow) overflow <= 1'b0;
      if (drop_c && (drop_cnt != '1)) drop_cnt <= drop_cnt + CNT_WIDTH'(1);
    end
  end

  capture_fifo #(
    .WIDTH (W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk    (clk),
    .rst_n  (rst_n),
    .push   (done_c),
    .wdata  (word_c),
    .pop    (out_ready),
    .rdata  (out_data),
    .valid  (out_valid),
    .level  (level),
    .full_c (full_c)
  );
endmodule

// File: tb/tb_nibble_capture_packer.sv
// Scoreboard bench for nibble_capture_packer with directed vectors.
module tb_nibble_capture_packer;
  import capture_pkg::*;

  logic                 clk = 1'b0;
  logic                 rst_n;
  logic                 in_valid, flush, out_ready, clear_overflow;
  logic [3:0]           in;
  logic                 out_valid;
  logic [7:0]           out_data;
  logic [2:0]           level;
  logic                 overflow;
  logic [7:0]           drop_cnt;

  int    n_checks = 0;
  int    n_fail   = 0;
  word_t exp_q[$];

  nibble_capture_packer dut (
    .clk            (clk),
    .rst_n          (rst_n),
    .in_valid       (in_valid),
    .in             (in),
    .flush          (flush),
    .out_valid      (out_valid),
    .out_ready      (out_ready),
    .out_data       (out_data),
    .level          (level),
    .overflow       (overflow),
    .clear_overflow (clear_overflow),
    .drop_cnt       (drop_cnt)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: every accepted head word must match the next expected word.
  always @(negedge clk) begin
    if (rst_n && out_valid && out_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_word: got 0x%0h expected none", out_data);
      end else begin
        check("word", 32'(out_data), 32'(exp_q.pop_front()));
      end
    end
  end

  task automatic drive(input logic v, input logic [3:0] d, input logic f, input logic clr);
    in_valid = v; in = d; flush = f; clear_overflow = clr;
    @(posedge clk); #1;
    in_valid = 0; flush = 0; clear_overflow = 0;
  endtask

  task automatic push_word(input logic [7:0] w, input bit expect_kept);
    if (expect_kept) exp_q.push_back(w);
    drive(1'b1, w[3:0], 1'b0, 1'b0);
    drive(1'b1, w[7:4], 1'b0, 1'b0);
  endtask

  task automatic wait_drain(input string name);
    int n = 0;
    out_ready = 1;
    while ((level != 0 || exp_q.size() != 0) && n < 50) begin
      @(posedge clk); #1;
      n++;
    end
    check({name, "_drained"}, 32'(n < 50), 32'd1);
  endtask

  initial begin
    rst_n = 0; in_valid = 0; in = '0; flush = 0; out_ready = 0; clear_overflow = 0;
    #22 rst_n = 1;
    @(negedge clk);
    check("rst_out_valid", 32'(out_valid), 0);
    check("rst_level",     32'(level), 0);
    check("rst_out_data",  32'(out_data), 0);
    check("rst_overflow",  32'(overflow), 0);
    check("rst_drop_cnt",  32'(drop_cnt), 0);
    @(posedge clk); #1;

    // Packing order and one-cycle latency.
    out_ready = 1;
    drive(1, 4'h3, 0, 0);
    exp_q.push_back(8'hA3);
    drive(1, 4'hA, 0, 0);
    @(negedge clk);
    check("pack_valid", 32'(out_valid), 1);
    check("pack_data",  32'(out_data), 32'hA3);
    @(negedge clk);
    check("pack_level_after_pop", 32'(level), 0);
    @(posedge clk); #1;

    // Flush of a partial word, empty flush, flush with a same-cycle sample.
    drive(1, 4'h5, 0, 0);
    exp_q.push_back(8'h05);
    drive(0, 4'h0, 1, 0);
    wait_drain("flush_partial");
    drive(0, 4'h0, 1, 0);
    @(negedge clk);
    check("flush_noop_level", 32'(level), 0);
    check("flush_noop_valid", 32'(out_valid), 0);
    @(posedge clk); #1;
    exp_q.push_back(8'h07);
    drive(1, 4'h7, 1, 0);
    wait_drain("flush_with_sample");

    // Back-pressure overflow: fifth word is dropped.
    out_ready = 0;
    push_word(8'h10, 1);
    push_word(8'h32, 1);
    push_word(8'h54, 1);
    push_word(8'h76, 1);
    push_word(8'h98, 0);
    @(negedge clk);
    check("ovf_level",    32'(level), 4);
    check("ovf_overflow", 32'(overflow), 1);
    check("ovf_drop_cnt", 32'(drop_cnt), 1);
    check("ovf_head",     32'(out_data), 32'h10);
    @(negedge clk);
    check("ovf_head_stable", 32'(out_data), 32'h10);
    wait_drain("ovf");

    // Clear alone drops overflow but keeps the count.
    drive(0, 4'h0, 0, 1);
    @(negedge clk);
    check("clear_overflow", 32'(overflow), 0);
    check("clear_drop_cnt", 32'(drop_cnt), 1);
    @(posedge clk); #1;

    // Full FIFO with simultaneous pop accepts the push.
    out_ready = 0;
    push_word(8'hB1, 1);
    push_word(8'hC2, 1);
    push_word(8'hD3, 1);
    push_word(8'hE4, 1);
    exp_q.push_back(8'hF5);
    drive(1, 4'h5, 0, 0);
    out_ready = 1;
    drive(1, 4'hF, 0, 0);
    out_ready = 0;
    @(negedge clk);
    check("fullpop_level",    32'(level), 4);
    check("fullpop_overflow", 32'(overflow), 0);
    check("fullpop_drop_cnt", 32'(drop_cnt), 1);
    check("fullpop_head",     32'(out_data), 32'hC2);
    wait_drain("fullpop");

    // Drop and clear in the same cycle: set wins.
    out_ready = 0;
    push_word(8'h10, 1);
    push_word(8'h32, 1);
    push_word(8'h54, 1);
    push_word(8'h76, 1);
    drive(1, 4'h1, 0, 0);
    drive(1, 4'h2, 0, 1);
    @(negedge clk);
    check("setwins_overflow", 32'(overflow), 1);
    check("setwins_drop_cnt", 32'(drop_cnt), 2);
    @(posedge clk); #1;
    drive(0, 4'h0, 0, 1);
    @(negedge clk);
    check("clear2_overflow", 32'(overflow), 0);
    check("clear2_drop_cnt", 32'(drop_cnt), 2);
    @(posedge clk); #1;
    // 298 further one-sample words bring the total to 300 drops.
    for (int i = 0; i < 298; i++) drive(1, 4'(i), 1, 0);
    @(negedge clk);
    check("sat_drop_cnt", 32'(drop_cnt), 255);
    check("sat_overflow", 32'(overflow), 1);
    check("sat_level",    32'(level), 4);
    wait_drain("sat");

    // Async reset mid-stream discards stored words and the partial lane.
    out_ready = 0;
    push_word(8'h11, 0);
    push_word(8'h22, 0);
    push_word(8'h33, 0);
    drive(1, 4'h9, 0, 0);
    @(negedge clk);
    check("prereset_level", 32'(level), 3);
    #2 rst_n = 0;
    #1;
    check("arst_out_valid", 32'(out_valid), 0);
    check("arst_level",     32'(level), 0);
    check("arst_out_data",  32'(out_data), 0);
    check("arst_overflow",  32'(overflow), 0);
    check("arst_drop_cnt",  32'(drop_cnt), 0);
    @(negedge clk);
    #2 rst_n = 1;
    @(posedge clk); #1;
    out_ready = 1;
    exp_q.push_back(8'h21);
    drive(1, 4'h1, 0, 0);
    drive(1, 4'h2, 0, 0);
    @(negedge clk);
    check("postrst_data", 32'(out_data), 32'h21);
    wait_drain("postrst");

    repeat (3) @(posedge clk);
    check("queue_empty", 32'(exp_q.size()), 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end
endmodule

// File: doc/nibble_capture_packer.md
Name: nibble_capture_packer

Overview:
- Downstream consumer of the 4-bit register-stage pipeline output.
- Packs PACK consecutive valid nibbles into one word and buffers words in a small show-ahead FIFO.
- Drains the FIFO over a ready/valid interface to the capture/trace side.
- Flags and counts words lost to back-pressure.

Parameters:
DATA_WIDTH, 4, width of one input sample (matches pipeline data width)
PACK, 2, samples per output word (>=1); output width W = DATA_WIDTH*PACK
DEPTH, 4, FIFO depth in words (power of 2, >=2)
CNT_WIDTH, 8, width of drop counter

Ports:
clk  input  1  clock, all state updates on posedge
rst_n  input  1  asynchronous active-low reset
in_valid  input  1  qualifies in this cycle
in  input  DATA_WIDTH  sample from pipeline output
flush  input  1  close current partial word, zero-padded
out_valid  output  1  FIFO head valid
out_ready  input  1  consumer accepts head
out_data  output  W  FIFO head word
level  output  clog2(DEPTH)+1  words currently stored
overflow  output  1  sticky: at least one word dropped
clear_overflow  input  1  clears overflow
drop_cnt  output  CNT_WIDTH  dropped words, saturating

Behaviour:
- Reset (async assert, sync-safe deassert): lane=0, partial=0, FIFO pointers and level=0, FIFO storage=0, out_valid=0, out_data=0, overflow=0, drop_cnt=0. Reset mid-operation discards partial and stored words; nothing is emitted afterwards.
- Lane order: first sample lands in bits [DATA_WIDTH-1:0], sample k lands in lane k. Unused lanes are 0.
- in_valid=1: sample is written into lane `lane`, and lane increments.
  - If lane==PACK-1 before the write, the word completes: lane becomes 0 and partial clears.
- flush=1 with lane!=0 or in_valid=1: the word completes after including any same-cycle sample; remaining lanes are 0; lane becomes 0.
- flush=1 with lane==0 and in_valid=0: no-op.
- Completed word push:
  - Accepted if level<DEPTH, or if a pop occurs in the same cycle (level==DEPTH with pop still accepts).
  - Otherwise the word is dropped: overflow is set, and drop_cnt increments, saturating at all-ones.
- Pop occurs when out_valid && out_ready.
- out_valid = (level!=0). out_data = head word; it is stable while out_valid && !out_ready.
- Latency: a word completing in cycle N is visible at the out_* ports in cycle N+1 when the FIFO was empty. No bypass in the same cycle.
- Simultaneous push and pop:
  - level is unchanged.
  - Empty FIFO cannot pop, so push proceeds alone.
  - Full FIFO accepts the push.
- Pointers wrap modulo DEPTH. level runs 0..DEPTH inclusive.
- clear_overflow clears overflow but does not touch drop_cnt. If a drop and a clear occur in the same cycle, set wins.
- out_ready while out_valid=0 is ignored.
- PACK==1: every valid sample is one word; flush is a no-op.

Decomposition:
- Shared package `capture_pkg`:
  - DATA_WIDTH/PACK/DEPTH defaults
  - word_t typedef (logic [W-1:0])
  - level width constant
- Sub-module `capture_fifo`: synchronous show-ahead FIFO with push/pop, full/empty, level, and async active-low reset.
- The packer lane logic and the drop accounting stay in the top module.

Test Plan:
- Packing order: reset, drive in_valid with 0x3 then 0xA (out_ready=1) -> one cycle after 0xA, out_valid=1 and out_data=0xA3; level returns to 0 after the pop.
- Flush partial: one sample 0x5, then flush=1 -> out_data=0x05. Flush with lane=0 and no valid -> no word, level unchanged. Sample 0x7 with flush in the same cycle -> word 0x07.
- Back-pressure overflow: out_ready=0, push 5 words 0x10,0x32,0x54,0x76,0x98 -> level=4, overflow=1, drop_cnt=1. Draining then yields 0x10,0x32,0x54,0x76 in order.
- Full with simultaneous pop: FIFO full, complete a word while out_ready=1 -> pop accepted, push accepted, level stays 4, no overflow.
- Sticky semantics: drop and clear_overflow in the same cycle -> overflow stays 1; clear alone -> 0 while drop_cnt holds. Force 300 drops with CNT_WIDTH=8 -> drop_cnt=255.
- Async reset mid-stream: assert rst_n=0 between clock edges with level=3 and lane=1 -> out_valid=0, level=0, out_data=0 immediately. After release, the next two samples 0x1,0x2 produce 0x21.
